quadrature_step_decoder: RTL and testbench

Upstream feeder for the 4-bit up/down counter. Converts a raw, asynchronous two-channel quadrature encoder input into a clean one-cycle step pulse and a direction level. The step output drives the counter's count enable and updown drives its direction input; updown=1 means increment. The block synchronises and glitch-filters both channels, decodes the Gray sequence, and flags illegal transitions.

---
 rtl/quadrature_step_decoder_if.sv | 30 +++
 rtl/quadrature_step_decoder.sv | 153 +++++++++++++++
 tb/tb_quadrature_step_decoder.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/quadrature_step_decoder_if.sv
// Bundles the encoder inputs and decoded outputs of quadrature_step_decoder.
// master: the side that drives the encoder lines and clr_err, and reads the results.
// slave : the decoder itself.
//   enc_a, enc_b : raw quadrature channels, asynchronous to clk
//   clr_err      : synchronous clear of err_cnt
//   ready        : decoding is live
//   step         : one-cycle pulse per valid quarter-step
//   updown       : direction of the most recent valid step (1 = up)
//   err          : one-cycle pulse on an illegal transition
//   err_cnt      : saturating count of illegal transitions
interface quadrature_step_decoder_if;
  logic       enc_a;
  logic       enc_b;
  logic       clr_err;
  logic       ready;
  logic       step;
  logic       updown;
  logic       err;
  logic [7:0] err_cnt;

  modport master (
    output enc_a, enc_b, clr_err,
    input  ready, step, updown, err, err_cnt
  );

  modport slave (
    input  enc_a, enc_b, clr_err,
    output ready, step, updown, err, err_cnt
  );
endinterface

// File: rtl/quadrature_step_decoder.sv
// Quadrature encoder front end: synchronises and glitch-filters both channels,
// decodes the Gray sequence into a one-cycle step pulse plus a direction level,
// and flags/counts illegal (both-bits-changed) transitions.
//   clk : system clock
//   rst : synchronous, active-high reset
//   bus : quadrature_step_decoder_if.slave (enc_a/enc_b/clr_err in,
//         ready/step/updown/err/err_cnt out)
//
// state | meaning
// INIT  | waiting for the synchronisers to fill; filtered/prev seeded from inputs
// RUN   | filtering and decoding live
module quadrature_step_decoder #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4
) (
  input logic                    clk,
  input logic                    rst,
  quadrature_step_decoder_if.slave bus
);

  localparam int FCW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int ICW = $clog2(SYNC_STAGES + 1);
  localparam logic [FCW-1:0] FLT_LAST  = FCW'(FILTER_LEN - 1);
  localparam logic [ICW-1:0] INIT_LOAD = ICW'(SYNC_STAGES);

  typedef enum logic {INIT, RUN} state_t;

  state_t           state, state_next;
  logic             load_init;

  logic [SYNC_STAGES-1:0] sync_a, sync_b;
  logic             a_s, b_s;
  logic             fa, fb;
  logic [FCW-1:0]   cnt_a, cnt_b;
  logic [1:0]       prev, cur;
  logic [ICW-1:0]   init_cnt;
  logic             is_up, is_down, is_err;

  logic             ready_q, step_q, updown_q, err_q;
  logic [7:0]       err_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= {sync_a[SYNC_STAGES-2:0], bus.enc_a};
      sync_b <= {sync_b[SYNC_STAGES-2:0], bus.enc_b};
    end
  end

  assign a_s = sync_a[SYNC_STAGES-1];
  assign b_s = sync_b[SYNC_STAGES-1];
  assign cur = {fa, fb};

  always_ff @(posedge clk) begin
    if (rst) state <= INIT;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    load_init  = 1'b0;
    case (state)
      INIT: if (init_cnt == '0) begin
        state_next = RUN;
        load_init  = 1'b1;
      end
      RUN: state_next = RUN;
      default: state_next = INIT;
    endcase
  end

  always_comb begin
    is_up   = 1'b0;
    is_down = 1'b0;
    is_err  = 1'b0;
    if (state == RUN) begin
      case ({prev, cur})
        4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: is_up   = 1'b1;
        4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: is_down = 1'b1;
        4'b00_11, 4'b11_00, 4'b10_01, 4'b01_10: is_err  = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      init_cnt  <= INIT_LOAD;
      fa        <= 1'b0;
      fb        <= 1'b0;
      cnt_a     <= '0;
      cnt_b     <= '0;
      prev      <= 2'b00;
      ready_q   <= 1'b0;
      step_q    <= 1'b0;
      err_q     <= 1'b0;
      updown_q  <= 1'b1;
      err_cnt_q <= 8'd0;
    end else begin
      step_q <= is_up | is_down;
      err_q  <= is_err;
      if (is_up)        updown_q <= 1'b1;
      else if (is_down) updown_q <= 1'b0;

      if (bus.clr_err)                   err_cnt_q <= {7'd0, is_err};
      else if (is_err && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;

      if (load_init) begin
        // Seed from the live input so an encoder resting at a non-00
        // position does not decode as an illegal jump from 00.
        fa      <= a_s;
        fb      <= b_s;
        prev    <= {a_s, b_s};
        ready_q <= 1'b1;
      end else if (state == INIT) begin
        init_cnt <= init_cnt - 1'b1;
      end else begin
        prev <= cur;

        if (a_s != fa) begin
          if (cnt_a == FLT_LAST) begin
            fa    <= ~fa;
            cnt_a <= '0;
          end else begin
            cnt_a <= cnt_a + 1'b1;
          end
        end else begin
          cnt_a <= '0;
        end

        if (b_s != fb) begin
          if (cnt_b == FLT_LAST) begin
            fb    <= ~fb;
            cnt_b <= '0;
          end else begin
            cnt_b <= cnt_b + 1'b1;
          end
        end else begin
          cnt_b <= '0;
        end
      end
    end
  end

  assign bus.ready   = ready_q;
  assign bus.step    = step_q;
  assign bus.updown  = updown_q;
  assign bus.err     = err_q;
  assign bus.err_cnt = err_cnt_q;

endmodule

// File: tb/tb_quadrature_step_decoder.sv
module tb_quadrature_step_decoder;

  logic clk;
  logic rst;

  quadrature_step_decoder_if bus ();

  quadrature_step_decoder #(.SYNC_STAGES(2), .FILTER_LEN(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic is_err;
    logic dir;
  } ev_t;

  ev_t sb_q[$];
  int  total  = 0;
  int  passed = 0;
  int  step_seen = 0;
  int  err_seen  = 0;
  logic prev_step = 1'b0;

  // Scoreboard monitor: every step/err pulse must match the oldest expectation.
  always @(negedge clk) begin
    ev_t e;
    if (bus.step && prev_step) begin
      total++;
      $display("FAIL step_width: step high on consecutive cycles, expected single-cycle pulse");
    end
    prev_step = bus.step;
    if (bus.step) step_seen++;
    if (bus.err)  err_seen++;
    if (bus.step || bus.err) begin
      total++;
      if (sb_q.size() == 0) begin
        $display("FAIL sb_unexpected: step=%0b err=%0b updown=%0b, expected no pulse",
                 bus.step, bus.err, bus.updown);
      end else begin
        e = sb_q.pop_front();
        if (bus.err !== e.is_err || bus.step !== !e.is_err ||
            (!e.is_err && bus.updown !== e.dir))
          $display("FAIL sb_event: step=%0b err=%0b updown=%0b, expected is_err=%0b dir=%0b",
                   bus.step, bus.err, bus.updown, e.is_err, e.dir);
        else
          passed++;
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", passed, total + 1);
    $fatal(1, "watchdog");
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset(input logic a, input logic b);
    @(negedge clk);
    bus.enc_a = a;
    bus.enc_b = b;
    rst = 1'b1;
    cycles(2);
    rst = 1'b0;
    cycles(3);
    sb_q.delete();
  endtask

  task automatic drive(input logic [1:0] lvl, input logic is_err, input logic dir, input int hold);
    bus.enc_a = lvl[1];
    bus.enc_b = lvl[0];
    sb_q.push_back('{is_err: is_err, dir: dir});
    cycles(hold);
  endtask

  task automatic check_drained(input string name);
    total++;
    if (sb_q.size() !== 0) $display("FAIL %s: %0d expected pulses not seen, expected 0", name, sb_q.size());
    else passed++;
  endtask

  task automatic test_reset();
    @(negedge clk);
    bus.enc_a = 1'b0; bus.enc_b = 1'b0; bus.clr_err = 1'b0;
    rst = 1'b1;
    cycles(3);
    total++;
    if ({bus.ready, bus.step, bus.err, bus.updown, bus.err_cnt} !== {4'b0001, 8'd0})
      $display("FAIL reset_values: ready=%0b step=%0b err=%0b updown=%0b err_cnt=%0d, expected 0 0 0 1 0",
               bus.ready, bus.step, bus.err, bus.updown, bus.err_cnt);
    else passed++;
    rst = 1'b0;
    cycles(2);
    total++;
    if (bus.ready !== 1'b0) $display("FAIL ready_early: ready=%0b, expected 0 after 2 edges", bus.ready);
    else passed++;
    cycles(1);
    total++;
    if (bus.ready !== 1'b1) $display("FAIL ready_on_time: ready=%0b, expected 1 after 3 edges", bus.ready);
    else passed++;
    cycles(10);
    total++;
    if ({bus.step, bus.err, bus.updown, bus.err_cnt} !== {3'b001, 8'd0})
      $display("FAIL reset_idle: step=%0b err=%0b updown=%0b err_cnt=%0d, expected 0 0 1 0",
               bus.step, bus.err, bus.updown, bus.err_cnt);
    else passed++;
  endtask

  task automatic test_reset_at_11();
    int e0;
    e0 = err_seen;
    do_reset(1'b1, 1'b1);
    total++;
    if (bus.ready !== 1'b1) $display("FAIL ready_at_11: ready=%0b, expected 1", bus.ready);
    else passed++;
    cycles(20);
    total++;
    if (bus.err_cnt !== 8'd0 || err_seen !== e0)
      $display("FAIL no_err_at_11: err_cnt=%0d err_pulses=%0d, expected 0 0", bus.err_cnt, err_seen - e0);
    else passed++;
  endtask

  task automatic test_up();
    logic [1:0] seq [4];
    int lat, s0;
    seq = '{2'b10, 2'b11, 2'b01, 2'b00};
    do_reset(1'b0, 1'b0);
    s0 = step_seen;
    lat = 0;
    bus.enc_a = 1'b1;
    sb_q.push_back('{is_err: 1'b0, dir: 1'b1});
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (bus.step && lat == 0) lat = k;
    end
    total++;
    if (lat !== 7) $display("FAIL step_latency: first step after %0d edges, expected 7", lat);
    else passed++;
    for (int i = 1; i < 16; i++) drive(seq[i % 4], 1'b0, 1'b1, 10);
    check_drained("up_drain");
    total++;
    if (step_seen - s0 !== 16 || ((step_seen - s0) % 16) !== 0)
      $display("FAIL up_count: steps=%0d, expected 16 (counter wraps to 0)", step_seen - s0);
    else passed++;
    total++;
    if (bus.updown !== 1'b1) $display("FAIL up_dir: updown=%0b, expected 1", bus.updown);
    else passed++;
  endtask

  task automatic test_down();
    drive(2'b01, 1'b0, 1'b0, 10);
    drive(2'b11, 1'b0, 1'b0, 10);
    drive(2'b10, 1'b0, 1'b0, 10);
    check_drained("down_drain");
    total++;
    if (bus.updown !== 1'b0) $display("FAIL down_dir: updown=%0b, expected 0", bus.updown);
    else passed++;
    drive(2'b11, 1'b0, 1'b1, 10);
    total++;
    if (bus.updown !== 1'b1) $display("FAIL up_after_down: updown=%0b, expected 1", bus.updown);
    else passed++;
    drive(2'b01, 1'b0, 1'b1, 10);
    drive(2'b00, 1'b0, 1'b1, 10);
    check_drained("down_tail");
  endtask

  task automatic test_glitch();
    int s0, e0;
    s0 = step_seen;
    e0 = err_seen;
    bus.enc_a = 1'b1;
    cycles(3);
    bus.enc_a = 1'b0;
    cycles(15);
    total++;
    if (step_seen !== s0 || err_seen !== e0)
      $display("FAIL glitch_3: steps=%0d errs=%0d, expected 0 0", step_seen - s0, err_seen - e0);
    else passed++;
    sb_q.push_back('{is_err: 1'b0, dir: 1'b1});
    sb_q.push_back('{is_err: 1'b0, dir: 1'b0});
    bus.enc_a = 1'b1;
    cycles(4);
    bus.enc_a = 1'b0;
    cycles(20);
    check_drained("glitch_4");
    total++;
    if (step_seen - s0 !== 2 || bus.updown !== 1'b0)
      $display("FAIL glitch_4_steps: steps=%0d updown=%0b, expected 2 0", step_seen - s0, bus.updown);
    else passed++;
  endtask

  task automatic test_errors();
    int e0;
    e0 = err_seen;
    for (int i = 0; i < 150; i++) begin
      drive(2'b11, 1'b1, 1'b0, 10);
      drive(2'b00, 1'b1, 1'b0, 10);
      if (i == 49) begin
        total++;
        if (bus.err_cnt !== 8'd100) $display("FAIL err_cnt_100: err_cnt=%0d, expected 100", bus.err_cnt);
        else passed++;
      end
    end
    check_drained("err_drain");
    total++;
    if (bus.err_cnt !== 8'd255 || err_seen - e0 !== 300)
      $display("FAIL err_saturate: err_cnt=%0d err_pulses=%0d, expected 255 300", bus.err_cnt, err_seen - e0);
    else passed++;
    total++;
    if (bus.updown !== 1'b0) $display("FAIL err_holds_dir: updown=%0b, expected 0", bus.updown);
    else passed++;

    bus.enc_a = 1'b1; bus.enc_b = 1'b1;
    sb_q.push_back('{is_err: 1'b1, dir: 1'b0});
    cycles(6);
    bus.clr_err = 1'b1;
    cycles(1);
    bus.clr_err = 1'b0;
    total++;
    if (bus.err !== 1'b1 || bus.err_cnt !== 8'd1)
      $display("FAIL clr_with_err: err=%0b err_cnt=%0d, expected 1 1", bus.err, bus.err_cnt);
    else passed++;
    cycles(5);

    bus.enc_a = 1'b0; bus.enc_b = 1'b0;
    cycles(3);
    rst = 1'b1;
    cycles(1);
    total++;
    if ({bus.ready, bus.step, bus.err, bus.updown, bus.err_cnt} !== {4'b0001, 8'd0})
      $display("FAIL mid_reset: ready=%0b step=%0b err=%0b updown=%0b err_cnt=%0d, expected 0 0 0 1 0",
               bus.ready, bus.step, bus.err, bus.updown, bus.err_cnt);
    else passed++;
    rst = 1'b0;
    sb_q.delete();
    cycles(3);
    total++;
    if (bus.ready !== 1'b1) $display("FAIL ready_after_mid_reset: ready=%0b, expected 1", bus.ready);
    else passed++;
    cycles(15);
    check_drained("mid_reset_quiet");

    drive(2'b11, 1'b1, 1'b0, 10);
    total++;
    if (bus.err_cnt !== 8'd1) $display("FAIL err_cnt_one: err_cnt=%0d, expected 1", bus.err_cnt);
    else passed++;
    bus.clr_err = 1'b1;
    cycles(1);
    bus.clr_err = 1'b0;
    total++;
    if (bus.err_cnt !== 8'd0) $display("FAIL clr_alone: err_cnt=%0d, expected 0", bus.err_cnt);
    else passed++;
    check_drained("final_drain");
  endtask

  initial begin
    rst = 1'b1;
    bus.enc_a = 1'b0;
    bus.enc_b = 1'b0;
    bus.clr_err = 1'b0;
    test_reset();
    test_reset_at_11();
    test_up();
    test_down();
    test_glitch();
    test_errors();
    cycles(2);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
